axi_ad9364_tx_sched: RTL

Transmit sample scheduler for the AD9364 digital interface. It buffers I/Q sample sets from an upstream valid/ready stream in a small FIFO. It then presents them to the interface's dac_valid/dac_data_* inputs on the fixed slot cadence the interface consumes: one slot every 2 clk cycles in 1R1T mode, every 4 in 2R2T mode. It sits between the DMA/DDS datapath and the digital interface instance, and owns mode latching, priming, underflow detection and stop sequencing.

---
 rtl/ad9364_pkg.sv | 26 ++
 rtl/ad9364_sample_fifo.sv | 70 +++++++
 rtl/axi_ad9364_tx_sched.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ad9364_pkg.sv
// Shared types and constants for the AD9364 transmit sample scheduler.
package ad9364_pkg;

   localparam int unsigned DATA_W    = 12;
   localparam int unsigned PERIOD_R1 = 2;
   localparam int unsigned PERIOD_R2 = 4;

   localparam logic [DATA_W-1:0] TONE_A_I = 12'o2064;
   localparam logic [DATA_W-1:0] TONE_A_Q = 12'o1753;
   localparam logic [DATA_W-1:0] TONE_B_I = 12'o4402;
   localparam logic [DATA_W-1:0] TONE_B_Q = 12'o1337;

   typedef struct packed {
      logic [DATA_W-1:0] i1;
      logic [DATA_W-1:0] q1;
      logic [DATA_W-1:0] i2;
      logic [DATA_W-1:0] q2;
   } sample_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

endpackage

// File: rtl/ad9364_sample_fifo.sv
// Synchronous FIFO of sample sets with occupancy count and single-cycle flush.
module ad9364_sample_fifo
   import ad9364_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  sample_t                wr_data,
   input  logic                   rd_en,
   input  logic                   flush,
   output sample_t                rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   sample_t       mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_ok, rd_ok;

   // Full blocks writes even when a read happens in the same cycle.
   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign wr_ok   = wr_en && !full && !flush;
   assign rd_ok   = rd_en && !empty && !flush;
   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/axi_ad9364_tx_sched.sv
// AD9364 transmit slot scheduler: FIFO-buffered samples emitted every 2 (1R1T) or 4 (2R2T) cycles.
// Optional built-in test tone enabled by defining AD9364_TX_SCHED_TONE_EN.
module axi_ad9364_tx_sched
   import ad9364_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned PRIME_LEVEL = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        r1_mode,
   input  logic        tone_sel,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [11:0] s_data_i1,
   input  logic [11:0] s_data_q1,
   input  logic [11:0] s_data_i2,
   input  logic [11:0] s_data_q2,
   output logic        dac_valid,
   output logic [11:0] dac_data_i1,
   output logic [11:0] dac_data_q1,
   output logic [11:0] dac_data_i2,
   output logic [11:0] dac_data_q2,
   output logic        dac_r1_mode,
   output logic        busy,
   output logic        underflow,
   output logic [15:0] underflow_count
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   state_t        state_q, state_d;
   logic [1:0]    phase_q, phase_d;
   logic          r1_q, r1_d;
   logic          valid_q, valid_d;
   sample_t       dac_q, dac_d;
   logic          uf_q, uf_d;
   logic [15:0]   uf_cnt_q, uf_cnt_d;
   logic          tone_b_q, tone_b_d;
   logic          tone_on;
   logic          pop, flush, last_phase;
   sample_t       wr_set, head;
   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty;

`ifdef AD9364_TX_SCHED_TONE_EN
   assign tone_on = tone_sel;
`else
   logic unused_tone_sel;
   assign unused_tone_sel = tone_sel;
   assign tone_on         = 1'b0;
`endif

   assign wr_set = '{i1: s_data_i1, q1: s_data_q1, i2: s_data_i2, q2: s_data_q2};

   ad9364_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (s_valid),
      .wr_data (wr_set),
      .rd_en   (pop),
      .flush   (flush),
      .rd_data (head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign last_phase = (phase_q == (r1_q ? 2'(PERIOD_R1 - 1) : 2'(PERIOD_R2 - 1)));

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      r1_d     = r1_q;
      valid_d  = 1'b0;
      dac_d    = dac_q;
      uf_d     = 1'b0;
      tone_b_d = tone_b_q;
      pop      = 1'b0;
      flush    = 1'b0;
      uf_cnt_d = (uf_q && uf_cnt_q != 16'hFFFF) ? uf_cnt_q + 16'd1 : uf_cnt_q;
      case (state_q)
         ST_IDLE: begin
            phase_d  = 2'd0;
            r1_d     = r1_mode;
            tone_b_d = 1'b0;
            if (enable) state_d = ST_PRIME;
         end
         ST_PRIME: begin
            phase_d = 2'd0;
            if (!enable) state_d = ST_IDLE;
            else if (tone_on || fifo_count >= CW'(PRIME_LEVEL)) state_d = ST_RUN;
         end
         ST_RUN: begin
            phase_d = last_phase ? 2'd0 : phase_q + 2'd1;
            if (phase_q == 2'd0) begin
               if (!enable) begin
                  state_d = ST_IDLE;
                  phase_d = 2'd0;
                  flush   = 1'b1;
               end else begin
                  valid_d = 1'b1;
                  if (tone_on) begin
                     dac_d.i1 = tone_b_q ? TONE_B_I : TONE_A_I;
                     dac_d.q1 = tone_b_q ? TONE_B_Q : TONE_A_Q;
                     dac_d.i2 = dac_d.i1;
                     dac_d.q2 = dac_d.q1;
                     tone_b_d = !tone_b_q;
                  end else if (!fifo_empty) begin
                     dac_d = head;
                     pop   = 1'b1;
                  end else begin
                     dac_d = '0;
                     uf_d  = 1'b1;
                  end
                  // Second channel pair is unused in 1R1T.
                  if (r1_q) begin
                     dac_d.i2 = '0;
                     dac_d.q2 = '0;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         phase_q  <= 2'd0;
         r1_q     <= 1'b0;
         valid_q  <= 1'b0;
         dac_q    <= '0;
         uf_q     <= 1'b0;
         uf_cnt_q <= 16'd0;
         tone_b_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         r1_q     <= r1_d;
         valid_q  <= valid_d;
         dac_q    <= dac_d;
         uf_q     <= uf_d;
         uf_cnt_q <= uf_cnt_d;
         tone_b_q <= tone_b_d;
      end
   end

   assign s_ready         = !fifo_full;
   assign dac_valid       = valid_q;
   assign dac_data_i1     = dac_q.i1;
   assign dac_data_q1     = dac_q.q1;
   assign dac_data_i2     = dac_q.i2;
   assign dac_data_q2     = dac_q.q2;
   assign dac_r1_mode     = r1_q;
   assign busy            = (state_q != ST_IDLE);
   assign underflow       = uf_q;
   assign underflow_count = uf_cnt_q;

endmodule
